// File: rtl/light_panel_input.sv
// Light panel front end: debounced on/off buttons and a 4x4 scanned keypad.
// Accepted events come out as single-cycle pulses with the last key code held.
module light_panel_input #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DIV        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_on_raw,
  input  logic       btn_off_raw,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       on_click,
  output logic       off_click,
  output logic       keypad,
  output logic [3:0] key_code,
  output logic       conflict
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DMAX = DW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_e;

  // bit 0 = on button, bit 1 = off button
  logic [1:0]    bs1_q, bs2_q;
  logic [1:0]    lvl_q, lvl_d;
  logic [1:0]    prev_q;
  logic [1:0]    rise;
  logic [CW-1:0] bcnt_q [2];
  logic [CW-1:0] bcnt_d [2];
  logic          onc_q, offc_q, conf_q, bevt_q;

  logic [3:0]    rs1_q, rs2_q;
  state_e        state_q, state_d;
  logic [3:0]    pat_q, pat_d;
  logic [1:0]    cidx_q, cidx_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] kcnt_q, kcnt_d;
  logic [3:0]    code_q, code_d;

  function automatic logic [1:0] low_row(input logic [3:0] r);
    logic [1:0] idx;
    if (r[0])      idx = 2'd0;
    else if (r[1]) idx = 2'd1;
    else if (r[2]) idx = 2'd2;
    else           idx = 2'd3;
    return idx;
  endfunction

  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < 2; i++) begin
      bcnt_d[i] = '0;
      if (bs2_q[i] != lvl_q[i]) begin
        if (bcnt_q[i] == CMAX) lvl_d[i] = bs2_q[i];
        else                   bcnt_d[i] = bcnt_q[i] + 1'b1;
      end
    end
  end

  assign rise = lvl_q & ~prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bs1_q  <= '0;
      bs2_q  <= '0;
      lvl_q  <= '0;
      prev_q <= '0;
      for (int i = 0; i < 2; i++) bcnt_q[i] <= '0;
      onc_q  <= 1'b0;
      offc_q <= 1'b0;
      conf_q <= 1'b0;
      bevt_q <= 1'b0;
    end else begin
      bs1_q  <= {btn_off_raw, btn_on_raw};
      bs2_q  <= bs1_q;
      lvl_q  <= lvl_d;
      prev_q <= lvl_q;
      for (int i = 0; i < 2; i++) bcnt_q[i] <= bcnt_d[i];
      onc_q  <= rise[0] & ~rise[1];
      offc_q <= rise[1] & ~rise[0];
      conf_q <= &rise;
      bevt_q <= |rise;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_q   <= '0;
      rs2_q   <= '0;
      state_q <= SCAN;
      pat_q   <= '0;
      cidx_q  <= '0;
      div_q   <= '0;
      kcnt_q  <= '0;
      code_q  <= '0;
    end else begin
      rs1_q   <= key_row;
      rs2_q   <= rs1_q;
      state_q <= state_d;
      pat_q   <= pat_d;
      cidx_q  <= cidx_d;
      div_q   <= div_d;
      kcnt_q  <= kcnt_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cidx_d  = cidx_q;
    div_d   = div_q;
    kcnt_d  = kcnt_q;
    code_d  = code_q;
    unique case (state_q)
      SCAN: begin
        if (rs2_q != 4'd0) begin
          pat_d   = rs2_q;
          kcnt_d  = '0;
          div_d   = '0;
          state_d = DEBOUNCE;
        end else if (div_q == DMAX) begin
          div_d  = '0;
          cidx_d = cidx_q + 2'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rs2_q != pat_q) begin
          kcnt_d  = '0;
          div_d   = '0;
          state_d = SCAN;
        end else if (kcnt_q == CMAX) begin
          kcnt_d  = '0;
          code_d  = {cidx_q, low_row(pat_q)};
          state_d = PRESSED;
        end else begin
          kcnt_d = kcnt_q + 1'b1;
        end
      end
      PRESSED: begin
        kcnt_d  = '0;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (rs2_q != 4'd0) begin
          kcnt_d = '0;
        end else if (kcnt_q == CMAX) begin
          kcnt_d  = '0;
          div_d   = '0;
          cidx_d  = cidx_q + 2'd1;
          state_d = SCAN;
        end else begin
          kcnt_d = kcnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    key_col   = 4'b0001 << cidx_q;
    key_code  = code_q;
    on_click  = onc_q;
    off_click = offc_q;
    conflict  = conf_q;
    keypad    = bevt_q | (state_q == PRESSED);
  end

endmodule

// File: tb/tb_light_panel_input.sv
// Bench for light_panel_input: random and directed stimulus, a spec-level
// reference model feeding an expected-event queue, and a decoupled monitor.
module tb_light_panel_input;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_on_raw, btn_off_raw;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       on_click, off_click, keypad, conflict;
  logic [3:0] key_code;
  logic [3:0] mat [4];

  light_panel_input #(.DEBOUNCE_CYCLES(DEB), .SCAN_DIV(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_on_raw (btn_on_raw),
    .btn_off_raw(btn_off_raw),
    .key_row    (key_row),
    .key_col    (key_col),
    .on_click   (on_click),
    .off_click  (off_click),
    .keypad     (keypad),
    .key_code   (key_code),
    .conflict   (conflict)
  );

  always #5 clk = ~clk;

  // physical keypad: a row line reads high when its key on the driven column is closed
  assign key_row = (key_col == 4'b0001) ? mat[0] :
                   (key_col == 4'b0010) ? mat[1] :
                   (key_col == 4'b0100) ? mat[2] :
                   (key_col == 4'b1000) ? mat[3] : 4'b0000;

  typedef struct {
    bit       on;
    bit       off;
    bit       conf;
    bit       is_key;
    bit [3:0] code;
    int       cyc;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_on = 0, n_off = 0, n_conf = 0, n_kp = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference model: the synchronized view of a button is its raw value two
  // clocks earlier; the accepted level flips once the last DEB synchronized
  // samples all disagree with it. A rising accepted level shows a pulse next cycle.
  bit hon[$], hoff[$], son[$], soff[$];
  bit lvl_on = 0, lvl_off = 0;

  function automatic bit all_differ(input bit s[$], input bit lvl);
    if (s.size() < DEB) return 0;
    foreach (s[i]) if (s[i] == lvl) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin
    bit seen_on, seen_off, r_on, r_off;
    exp_t keep[$];
    exp_t e;
    cyc++;
    if (reset) begin
      hon = '{0, 0};
      hoff = '{0, 0};
      son.delete();
      soff.delete();
      lvl_on = 0;
      lvl_off = 0;
      foreach (q[i]) if (q[i].is_key || q[i].cyc < cyc - 1) keep.push_back(q[i]);
      q = keep;
    end else begin
      hon.push_back(btn_on_raw);
      hoff.push_back(btn_off_raw);
      while (hon.size() > 3) void'(hon.pop_front());
      while (hoff.size() > 3) void'(hoff.pop_front());
      seen_on = hon[0];
      seen_off = hoff[0];
      son.push_back(seen_on);
      soff.push_back(seen_off);
      while (son.size() > DEB) void'(son.pop_front());
      while (soff.size() > DEB) void'(soff.pop_front());
      r_on = 0;
      r_off = 0;
      if (all_differ(son, lvl_on)) begin
        lvl_on = !lvl_on;
        r_on = lvl_on;
      end
      if (all_differ(soff, lvl_off)) begin
        lvl_off = !lvl_off;
        r_off = lvl_off;
      end
      if (r_on || r_off) begin
        e.on = r_on && !r_off;
        e.off = r_off && !r_on;
        e.conf = r_on && r_off;
        e.is_key = 0;
        e.code = 4'd0;
        e.cyc = cyc + 1;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (keypad) begin
        n_kp++;
        if (on_click) n_on++;
        if (off_click) n_off++;
        if (conflict) n_conf++;
        if (q.size() == 0) begin
          check("unexpected_keypad", 1, 0);
        end else begin
          e = q.pop_front();
          check("on_click", on_click, e.on);
          check("off_click", off_click, e.off);
          check("conflict", conflict, e.conf);
          if (e.is_key) check("key_code", key_code, e.code);
          if (e.cyc >= 0) check("pulse_cycle", cyc, e.cyc);
        end
      end else begin
        check("stray_pulse", {on_click, off_click, conflict}, 3'b000);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_col(input int c);
    logic [3:0] tgt;
    int n;
    tgt = 4'b0001 << c;
    n = 0;
    while (key_col == tgt && n < 80) begin tick(1); n++; end
    while (key_col != tgt && n < 80) begin tick(1); n++; end
    check("col_arrive", key_col, tgt);
  endtask

  task automatic expect_key(input bit [3:0] code);
    exp_t e;
    e.on = 0;
    e.off = 0;
    e.conf = 0;
    e.is_key = 1;
    e.code = code;
    e.cyc = -1;
    q.push_back(e);
  endtask

  function automatic bit [1:0] lowest(input bit [3:0] p);
    bit [1:0] lo;
    lo = 0;
    for (int b = 3; b >= 0; b--) if (p[b]) lo = 2'(b);
    return lo;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_on, hold_off, rst_left;
    int kp0, on0, off0, cf0;
    bit [3:0] pat;
    int c;
    reset = 1;
    btn_on_raw = 0;
    btn_off_raw = 0;
    for (int i = 0; i < 4; i++) mat[i] = 4'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_key_col", key_col, 4'b0001);
    check("rst_key_code", key_code, 4'd0);
    check("rst_pulses", {on_click, off_click, keypad, conflict}, 4'd0);
    tick(1);
    reset = 0;

    hold_on = 0;
    hold_off = 0;
    rst_left = 0;
    for (int t = 0; t < 3000; t++) begin
      tick(1);
      if (hold_on == 0) begin
        btn_on_raw = 1'($urandom_range(0, 1));
        hold_on = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 12);
      end else hold_on--;
      if (hold_off == 0) begin
        btn_off_raw = 1'($urandom_range(0, 1));
        hold_off = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 12);
      end else hold_off--;
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset = 0;
      end else if ($urandom_range(0, 299) == 0) begin
        reset = 1;
        rst_left = $urandom_range(1, 3);
      end
    end
    reset = 0;
    btn_on_raw = 0;
    btn_off_raw = 0;
    tick(30);
    check("random_drain", q.size(), 0);

    kp0 = n_kp; on0 = n_on; off0 = n_off;
    for (int g = 0; g < 3; g++) begin
      btn_on_raw = 1; tick(1);
      btn_on_raw = 0; tick(1);
    end
    btn_on_raw = 1; tick(20);
    btn_on_raw = 0; tick(20);
    check("glitch_on_count", n_on - on0, 1);
    check("glitch_kp_count", n_kp - kp0, 1);
    check("glitch_off_count", n_off - off0, 0);

    kp0 = n_kp; on0 = n_on; off0 = n_off; cf0 = n_conf;
    btn_on_raw = 1; btn_off_raw = 1; tick(10);
    btn_on_raw = 0; btn_off_raw = 0; tick(20);
    check("both_conf_count", n_conf - cf0, 1);
    check("both_kp_count", n_kp - kp0, 1);
    check("both_clicks", (n_on - on0) + (n_off - off0), 0);

    kp0 = n_kp; off0 = n_off;
    btn_off_raw = 1; tick(4);
    reset = 1; tick(2);
    reset = 0; tick(20);
    btn_off_raw = 0; tick(20);
    check("rst_off_count", n_off - off0, 1);
    check("rst_kp_count", n_kp - kp0, 1);

    kp0 = n_kp;
    wait_col(1);
    expect_key(4'b0110);
    mat[1] = 4'b0100;
    tick(30);
    check("held_col", key_col, 4'b0010);
    check("held_code", key_code, 4'b0110);
    mat[1] = 4'b0000;
    tick(3);
    check("release_col_frozen", key_col, 4'b0010);
    tick(7);
    check("release_col_next", key_col, 4'b0100);
    tick(10);
    check("c1_kp_count", n_kp - kp0, 1);

    kp0 = n_kp;
    wait_col(0);
    for (int g = 0; g < 4; g++) begin
      mat[0] = 4'b0001; tick(2);
      mat[0] = 4'b0000; tick(2);
    end
    check("bounce_col", key_col, 4'b0001);
    tick(20);
    check("bounce_kp_count", n_kp - kp0, 0);

    kp0 = n_kp;
    wait_col(3);
    expect_key(4'b1101);
    mat[3] = 4'b1010;
    tick(20);
    mat[3] = 4'b0000;
    tick(20);
    check("multi_kp_count", n_kp - kp0, 1);
    check("multi_code", key_code, 4'b1101);

    for (int k = 0; k < 6; k++) begin
      c = $urandom_range(0, 3);
      pat = 4'($urandom_range(1, 15));
      wait_col(c);
      expect_key({2'(c), lowest(pat)});
      mat[c] = pat;
      tick($urandom_range(10, 25));
      mat[c] = 4'b0000;
      tick(20);
    end

    tick(10);
    check("final_drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/light_panel_input.md
LIGHT_PANEL_INPUT -- requirements
Module: light_panel_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a press or a release.
REQ-002 Parameter SCAN_DIV, default 8: clock cycles each keypad column stays driven while scanning.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_on_raw  input  1  raw, bouncing "turn on" push button; high = pressed.
REQ-006 btn_off_raw  input  1  raw, bouncing "turn off" push button; high = pressed.
REQ-007 key_row  input  4  raw keypad row sense lines; high = key closed on the driven column.
REQ-008 key_col  output  4  one-hot keypad column drive.
REQ-009 on_click  output  1  one-cycle pulse; accepted on-button press.
REQ-010 off_click  output  1  one-cycle pulse; accepted off-button press.
REQ-011 keypad  output  1  one-cycle pulse; any accepted event (key press, on_click or off_click).
REQ-012 key_code  output  4  {column index[1:0], row index[1:0]} of the last accepted key; held until the next accepted key.
REQ-013 conflict  output  1  one-cycle pulse; on and off presses accepted in the same cycle.

Function
REQ-014 btn_on_raw, btn_off_raw and key_row SHALL each pass through a 2-flop synchronizer before any other use.
REQ-015 Each button SHALL have its own debounce counter; a synchronized level differing from the debounced level for DEBOUNCE_CYCLES consecutive cycles SHALL update the debounced level; any reversion SHALL clear the counter.
REQ-016 On a debounced 0->1 transition, the matching click output SHALL pulse high for exactly one cycle, in the cycle after the update; debounced 1->0 transitions produce no pulse.
REQ-017 If both debounced levels rise in the same cycle, on_click and off_click SHALL stay low, and conflict and keypad SHALL pulse once.
REQ-018 Holding a button SHALL produce exactly one pulse; a new pulse requires an accepted release followed by an accepted press.
REQ-019 The scanner FSM SHALL have the states SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-020 SCAN: key_col advances 0001->0010->0100->1000->0001 every SCAN_DIV cycles; a nonzero synchronized key_row SHALL freeze key_col, capture the row pattern and enter DEBOUNCE.
REQ-021 DEBOUNCE: the captured pattern held for DEBOUNCE_CYCLES consecutive cycles SHALL enter PRESSED; any change SHALL return to SCAN on the same column with the counter and divider cleared.
REQ-022 PRESSED lasts one cycle: key_code SHALL load {col index, index of lowest set row bit}, keypad SHALL pulse in that cycle, then the FSM SHALL enter RELEASE.
REQ-023 RELEASE: key_row zero for DEBOUNCE_CYCLES consecutive cycles SHALL return to SCAN and advance key_col to the next column; a nonzero row SHALL clear the counter.
REQ-024 Multiple simultaneously closed rows SHALL report only the lowest-index row; no second event until release.
REQ-025 A key acceptance coinciding with a button acceptance SHALL produce a single keypad pulse; key_code updates and click outputs behave normally.
REQ-026 Counters SHALL saturate and never wrap; DEBOUNCE_CYCLES=1 SHALL accept after one stable cycle.

Reset
REQ-027 While reset is high: key_col=0001, on_click=off_click=keypad=conflict=0, key_code=0, FSM=SCAN, all counters, synchronizers and debounced levels=0.
REQ-028 Reset asserted mid-debounce or mid-press SHALL discard the event; after release, a button held through reset is accepted as a fresh press after sync plus DEBOUNCE_CYCLES.
REQ-029 After release, no output pulse SHALL occur unless an input is held stable for at least DEBOUNCE_CYCLES.

Verification
REQ-030 btn_on_raw held high 20 cycles after 3 cycles of 1-cycle glitches -> exactly one on_click and one keypad pulse, about 2+4+1 cycles after the stable edge; off_click=0.
REQ-031 btn_on_raw and btn_off_raw rise on the same cycle, held 10 cycles -> one conflict and one keypad pulse; on_click=off_click=0.
REQ-032 key_row=0100 while key_col=0010, held 30 cycles -> one keypad pulse, key_code=4'b0110, key_col frozen at 0010 until 4 zero cycles, then 0100.
REQ-033 key_row toggles 0001/0000 every 2 cycles during DEBOUNCE -> no keypad pulse; FSM returns to SCAN on the same column.
REQ-034 key_row=1010 on column 3 -> key_code=4'b1101, single pulse.
REQ-035 Reset pulse during DEBOUNCE with btn_off_raw held -> no pulse during reset; exactly one off_click after sync plus 4 cycles once reset is released.
